// File: rtl/mem_access_unit.sv
// Load/store stage: word-addressed memory access over a req/ack handshake with byte strobes.
// Optional macro MEM_ACCESS_MISALIGN_SPLIT_EN: word-crossing accesses run as two beats instead of erroring.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_wsel,
    input  logic [2:0]  req_rsel,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // state | meaning
    // IDLE  | ready for a request
    // BEAT0 | first (or only) memory beat; error requests pass through here without a beat
    // BEAT1 | second beat of a word-crossing access
    // RESP  | one-cycle response pulse
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t      state, next_state;
    logic [2:0]  size_d;
    logic        illegal_d, cross_d, err_d;
    logic [3:0]  mask_d, strb_lo_d;
    logic [31:0] wdata_lo_d;
    logic        q_we, q_err;
    logic [1:0]  q_off;
    logic [2:0]  q_rsel;
    logic [CW-1:0] cnt;
    logic        tmo;
    logic [63:0] rd_wide;
    logic [31:0] rd_shift, rd_ext;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
    logic        split_d, q_split;
    logic [3:0]  strb_hi_d, q_strb_hi;
    logic [31:0] wdata_hi_d, q_wdata_hi, q_low;
`endif

    always_comb begin
        size_d    = 3'd4;
        illegal_d = 1'b0;
        if (req_we) begin
            case (req_wsel)
                2'b00:   size_d = 3'd4;
                2'b01:   size_d = 3'd1;
                2'b11:   size_d = 3'd2;
                default: illegal_d = 1'b1;
            endcase
        end else begin
            case (req_rsel)
                3'b000:         size_d = 3'd4;
                3'b001, 3'b011: size_d = 3'd1;
                3'b010, 3'b100: size_d = 3'd2;
                default:        illegal_d = 1'b1;
            endcase
        end
        cross_d    = ({1'b0, req_addr[1:0]} + size_d) > 3'd4;
        mask_d     = (size_d == 3'd4) ? 4'b1111 : (size_d == 3'd2) ? 4'b0011 : 4'b0001;
        strb_lo_d  = 4'(mask_d << req_addr[1:0]);
        wdata_lo_d = 32'(req_wdata << {req_addr[1:0], 3'b000});
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
        strb_hi_d  = 4'(({4'b0000, mask_d} << req_addr[1:0]) >> 4);
        wdata_hi_d = 32'(({32'd0, req_wdata} << {req_addr[1:0], 3'b000}) >> 32);
        split_d    = cross_d && !illegal_d;
        err_d      = illegal_d;
`else
        err_d      = illegal_d || cross_d;
`endif
    end

    // Ack in the terminal-count cycle still wins over the timeout.
    assign tmo       = (TIMEOUT != 0) && (cnt == '0) && !mem_ack;
    assign req_ready = (state == IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (req_valid) next_state = BEAT0;
            BEAT0: begin
                if (q_err) next_state = RESP;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
                else if (mem_ack) next_state = q_split ? BEAT1 : RESP;
`else
                else if (mem_ack) next_state = RESP;
`endif
                else if (tmo) next_state = RESP;
            end
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
            BEAT1: if (mem_ack || tmo) next_state = RESP;
`endif
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
        rd_wide = (state == BEAT1) ? {mem_rdata, q_low} : {32'd0, mem_rdata};
`else
        rd_wide = {32'd0, mem_rdata};
`endif
        rd_shift = 32'(rd_wide >> {q_off, 3'b000});
        case (q_rsel)
            3'b001:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b010:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b011:  rd_ext = {24'd0, rd_shift[7:0]};
            3'b100:  rd_ext = {16'd0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            q_we       <= 1'b0;
            q_err      <= 1'b0;
            q_off      <= '0;
            q_rsel     <= '0;
            cnt        <= '0;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
            q_split    <= 1'b0;
            q_strb_hi  <= '0;
            q_wdata_hi <= '0;
            q_low      <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    q_we   <= req_we;
                    q_err  <= err_d;
                    q_off  <= req_addr[1:0];
                    q_rsel <= req_rsel;
                    cnt    <= CW'(TIMEOUT - 1);
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
                    q_split    <= split_d;
                    q_strb_hi  <= req_we ? strb_hi_d : 4'b0000;
                    q_wdata_hi <= req_we ? wdata_hi_d : 32'd0;
`endif
                    if (!err_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wstrb <= req_we ? strb_lo_d : 4'b0000;
                        mem_wdata <= req_we ? wdata_lo_d : 32'd0;
                    end
                end
                BEAT0, BEAT1: begin
                    if (next_state == RESP) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wstrb  <= '0;
                        mem_wdata  <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= q_err || !mem_ack;
                        resp_rdata <= (q_err || !mem_ack || q_we) ? 32'd0 : rd_ext;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
                    end else if (next_state == BEAT1) begin
                        q_low     <= mem_rdata;
                        mem_addr  <= mem_addr + 32'd4;
                        mem_wstrb <= q_strb_hi;
                        mem_wdata <= q_wdata_hi;
                        cnt       <= CW'(TIMEOUT - 1);
`endif
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default TIMEOUT = 16).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_wsel;
    logic [2:0]  req_rsel;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    int n_checks = 0;
    int n_fail = 0;
    int cycles;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wsel(req_wsel), .req_rsel(req_rsel),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] wsel, input logic [2:0] rsel);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_wsel = wsel; req_rsel = rsel;
        tick();
        req_valid = 1'b0;
    endtask

    // Legal single-beat access with an ack in the first request cycle.
    task automatic single(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] wsel, input logic [2:0] rsel,
                          input logic [31:0] rword, input logic [31:0] e_addr,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata,
                          input logic [31:0] e_rdata);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        issue(we, addr, wdata, wsel, rsel);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, e_addr);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
        chk({tag, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, e_strb});
        if (we) chk({tag, "_wdata"}, mem_wdata, e_wdata);
        mem_ack = 1'b1; mem_rdata = rword;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        chk({tag, "_rdata"}, resp_rdata, e_rdata);
        chk({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
        tick();
        chk({tag, "_resp_pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    // Request that must error out without any memory beat, response two cycles after accept.
    task automatic err_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [1:0] wsel, input logic [2:0] rsel);
        issue(we, addr, 32'h5A5A5A5A, wsel, rsel);
        chk({tag, "_no_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_early"}, {31'd0, resp_valid}, 32'd0);
        tick();
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd1);
        chk({tag, "_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_no_req2"}, {31'd0, mem_req}, 32'd0);
        tick();
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wsel = 0; req_rsel = 0;
        mem_ack = 0; mem_rdata = 0;
        #2;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        single("t1_lb", 1'b0, 32'h103, 32'd0, 2'b00, 3'b001, 32'h80AABBCC,
               32'h100, 4'b0000, 32'd0, 32'hFFFFFF80);
        chk("t1_hold", resp_rdata, 32'hFFFFFF80);
        single("t2_sh", 1'b1, 32'h202, 32'h00001234, 2'b11, 3'b000, 32'hFFFFFFFF,
               32'h200, 4'b1100, 32'h12340000, 32'd0);
        single("sb_off1", 1'b1, 32'h1, 32'h000000AB, 2'b01, 3'b000, 32'd0,
               32'h0, 4'b0010, 32'h0000AB00, 32'd0);
        single("sw", 1'b1, 32'h10, 32'hCAFEF00D, 2'b00, 3'b000, 32'd0,
               32'h10, 4'b1111, 32'hCAFEF00D, 32'd0);
        single("lh_off2", 1'b0, 32'h6, 32'd0, 2'b00, 3'b010, 32'h80011234,
               32'h4, 4'b0000, 32'd0, 32'hFFFF8001);
        single("lhu_off1", 1'b0, 32'h501, 32'd0, 2'b00, 3'b100, 32'h00ABCD00,
               32'h500, 4'b0000, 32'd0, 32'h0000ABCD);
        single("lbu", 1'b0, 32'h2, 32'd0, 2'b00, 3'b011, 32'h00F00000,
               32'h0, 4'b0000, 32'd0, 32'h000000F0);

`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
        issue(1'b0, 32'h301, 32'd0, 2'b00, 3'b000);
        chk("t3_b0_req", {31'd0, mem_req}, 32'd1);
        chk("t3_b0_addr", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'h44332211;
        tick();
        mem_rdata = 32'h88776655;
        chk("t3_b1_req", {31'd0, mem_req}, 32'd1);
        chk("t3_b1_addr", mem_addr, 32'h304);
        chk("t3_b1_nresp", {31'd0, resp_valid}, 32'd0);
        tick();
        mem_ack = 1'b0;
        chk("t3_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("t3_resp_err", {31'd0, resp_err}, 32'd0);
        chk("t3_rdata", resp_rdata, 32'h55443322);
        tick();
`else
        err_access("t3_lw_cross", 1'b0, 32'h301, 2'b00, 3'b000);
        err_access("lh_off3", 1'b0, 32'h403, 2'b00, 3'b010);
`endif

        issue(1'b0, 32'h400, 32'd0, 2'b00, 3'b000);
        cycles = 0;
        while (mem_req && cycles < 40) begin
            cycles++;
            tick();
        end
        chk("t4_req_cycles", cycles, 32'd16);
        chk("t4_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("t4_resp_err", {31'd0, resp_err}, 32'd1);
        chk("t4_rdata", resp_rdata, 32'd0);
        tick();
        single("t4_next", 1'b0, 32'h10, 32'd0, 2'b00, 3'b000, 32'hDEADBEEF,
               32'h10, 4'b0000, 32'd0, 32'hDEADBEEF);

        err_access("t5_rsel101", 1'b0, 32'h20, 2'b00, 3'b101);
        err_access("wsel10", 1'b1, 32'h24, 2'b10, 3'b000);

        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_ack_nresp", {31'd0, resp_valid}, 32'd0);

        issue(1'b0, 32'h80, 32'd0, 2'b00, 3'b000);
        chk("t6_req_before", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_async", {31'd0, mem_req}, 32'd0);
        chk("t6_ready_async", {31'd0, req_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        chk("t6_ready", {31'd0, req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
